// File: rtl/ustc_pkg.sv
// ustc_pkg: shared widths and FSM state encoding for the ustc_psum column scheduler.
//   DW_DATA/DW_ROW/DW_CTRL : fields of one packed psum input line
//   DW_COL                 : column index width
//   DW_LINE                : full line width (data + row + ctrl)
//   state_e                : IDLE=0, FEED=1, FLUSH=2, OUT=3
package ustc_pkg;
    localparam int DW_DATA = 8;
    localparam int DW_ROW  = 4;
    localparam int DW_CTRL = 4;
    localparam int DW_COL  = 4;
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_e;
endpackage

// File: rtl/ustc_res_reg.sv
// ustc_res_reg: single-entry result holding register for the scheduler OUT stage.
//   clk, rst      : clock, asynchronous active-low reset
//   load_i        : capture data_i/col_i and raise valid_o
//   data_i, col_i : psum result and its column
//   ready_i       : downstream accepts; valid_o clears on valid_o & ready_i
//   valid_o       : entry holds a result
//   data_o, col_o : held result, stable while valid_o & ~ready_i
module ustc_res_reg #(
    parameter int DW_OUT = 128,
    parameter int DW_COL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DW_OUT-1:0] data_i,
    input  logic [DW_COL-1:0] col_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DW_OUT-1:0] data_o,
    output logic [DW_COL-1:0] col_o
);
    logic              valid_q;
    logic [DW_OUT-1:0] data_q;
    logic [DW_COL-1:0] col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
        end else begin
            valid_q <= load_i | (valid_q & ~ready_i);
            if (load_i) begin
                data_q <= data_i;
                col_q  <= col_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign col_o   = col_q;
endmodule

// File: rtl/ustc_psum_sched.sv
// ustc_psum_sched: column scheduler feeding packed beats into ustc_psum and returning per-column results.
//   clk, rst                      : clock, asynchronous active-low reset
//   start, cfg_ncols_m1,
//   cfg_kbeats_m1                 : job launch and its shape (columns-1, beats per column-1)
//   busy, done                    : job in progress, one-cycle end-of-job pulse
//   in_valid, in_ready, in_data   : upstream beat stream
//   psum_col, psum_in             : column index and registered lines to ustc_psum
//   psum_out_en, psum_out_valid,
//   psum_out                      : result request / response from ustc_psum
//   res_valid, res_ready,
//   res_data, res_col             : downstream result stream
//   perf_in_stall, perf_out_stall : stall counters when USTC_PSUM_SCHED_PERF_EN is defined, else 0
module ustc_psum_sched #(
    parameter int N       = 16,
    parameter int NUM_IN  = 32,
    parameter int DW_DATA = ustc_pkg::DW_DATA,
    parameter int DW_ROW  = ustc_pkg::DW_ROW,
    parameter int DW_CTRL = ustc_pkg::DW_CTRL,
    parameter int DW_COL  = ustc_pkg::DW_COL,
    parameter int DW_KB   = 8,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int DW_OUT  = N * DW_DATA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DW_COL-1:0]         cfg_ncols_m1,
    input  logic [DW_KB-1:0]          cfg_kbeats_m1,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_LINE-1:0] in_data,
    output logic [DW_COL-1:0]         psum_col,
    output logic [NUM_IN*DW_LINE-1:0] psum_in,
    output logic                      psum_out_en,
    input  logic                      psum_out_valid,
    input  logic [DW_OUT-1:0]         psum_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DW_OUT-1:0]         res_data,
    output logic [DW_COL-1:0]         res_col,
    output logic [31:0]               perf_in_stall,
    output logic [31:0]               perf_out_stall
);
    import ustc_pkg::*;

    state_e                    state_q;
    logic [DW_COL-1:0]         ncols_q, col_q;
    logic [DW_KB-1:0]          kbeats_q, beat_q;
    logic                      done_q, en_q;
    logic [NUM_IN*DW_LINE-1:0] pin_q;
    logic                      accept, cap;

    assign in_ready    = state_q == FEED;
    assign accept      = in_valid & in_ready;
    // A result is only taken once the request has actually been raised, so a
    // stray valid in the first FLUSH cycle cannot capture a stale sum.
    assign cap         = (state_q == FLUSH) & en_q & psum_out_valid;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign psum_col    = col_q;
    assign psum_in     = pin_q;
    assign psum_out_en = en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ncols_q  <= '0;
            kbeats_q <= '0;
            col_q    <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            pin_q    <= '0;
        end else begin
            done_q <= 1'b0;
            // Request is raised one cycle after entering FLUSH so the last beat
            // has passed through the psum_in register into ustc_psum.
            en_q   <= (state_q == FLUSH) & ~cap;
            // Bubbles are all-zero lines (ctrl=0), which ustc_psum treats as no-ops.
            pin_q  <= accept ? in_data : '0;
            case (state_q)
                IDLE: if (start) begin
                    ncols_q  <= cfg_ncols_m1;
                    kbeats_q <= cfg_kbeats_m1;
                    col_q    <= '0;
                    beat_q   <= '0;
                    state_q  <= FEED;
                end
                FEED: if (accept) begin
                    if (beat_q == kbeats_q) state_q <= FLUSH;
                    else beat_q <= beat_q + 1'b1;
                end
                FLUSH: if (cap) state_q <= OUT;
                OUT: if (res_ready) begin
                    if (col_q == ncols_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        beat_q  <= '0;
                        state_q <= FEED;
                    end
                end
            endcase
        end
    end

    ustc_res_reg #(
        .DW_OUT(DW_OUT),
        .DW_COL(DW_COL)
    ) u_res (
        .clk    (clk),
        .rst    (rst),
        .load_i (cap),
        .data_i (psum_out),
        .col_i  (col_q),
        .ready_i(res_ready),
        .valid_o(res_valid),
        .data_o (res_data),
        .col_o  (res_col)
    );

`ifdef USTC_PSUM_SCHED_PERF_EN
    logic [31:0] in_stall_q, out_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_stall_q  <= '0;
            out_stall_q <= '0;
        end else if ((state_q == IDLE) & start) begin
            in_stall_q  <= '0;
            out_stall_q <= '0;
        end else begin
            if ((state_q == FEED) & ~in_valid & ~&in_stall_q) in_stall_q <= in_stall_q + 1'b1;
            if ((state_q == OUT) & ~res_ready & ~&out_stall_q) out_stall_q <= out_stall_q + 1'b1;
        end
    end

    assign perf_in_stall  = in_stall_q;
    assign perf_out_stall = out_stall_q;
`else
    assign perf_in_stall  = '0;
    assign perf_out_stall = '0;
`endif
endmodule

// File: tb/tb_ustc_psum_sched.sv
// tb_ustc_psum_sched: randomized self-checking bench for ustc_psum_sched with a psum stub and job-level reference model.
module tb_ustc_psum_sched;
    localparam logic [127:0] FIXED = 128'h0102030405060708090a0b0c0d0e0f10;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [3:0]   cfg_ncols_m1 = '0;
    logic [7:0]   cfg_kbeats_m1 = '0;
    logic         busy, done, in_ready, psum_out_en, res_valid;
    logic         in_valid = 1'b0, res_ready = 1'b0;
    logic [511:0] in_data = '0, psum_in;
    logic [3:0]   psum_col, res_col;
    logic         psum_out_valid;
    logic [127:0] psum_out, res_data;
    logic [31:0]  perf_in_stall, perf_out_stall;
    int           n_cmp = 0, n_bad = 0;
    bit           fixed_mode = 1'b0;
    logic [127:0] m_acc;
    int           m_cnt;

    always #5 clk = ~clk;

    ustc_psum_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ncols_m1(cfg_ncols_m1), .cfg_kbeats_m1(cfg_kbeats_m1),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .psum_col(psum_col), .psum_in(psum_in), .psum_out_en(psum_out_en), .psum_out_valid(psum_out_valid),
        .psum_out(psum_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_col(res_col), .perf_in_stall(perf_in_stall), .perf_out_stall(perf_out_stall)
    );

    function automatic logic [127:0] fold(input logic [511:0] b);
        return b[127:0] ^ b[255:128] ^ b[383:256] ^ b[511:384];
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        b[0] = 1'b1;
        return b;
    endfunction

    // psum stub: XOR-folds every line it receives; answers two cycles after a
    // request with the folded sum tagged by the column it was asked for.
    always @(posedge clk) begin
        if (!rst) begin
            m_acc <= '0;
            m_cnt <= 0;
            psum_out_valid <= 1'b0;
            psum_out <= '0;
        end else begin
            m_acc <= psum_out_valid ? fold(psum_in) : (m_acc ^ fold(psum_in));
            m_cnt <= psum_out_en ? m_cnt + 1 : 0;
            psum_out_valid <= psum_out_en && m_cnt == 1;
            psum_out <= fixed_mode ? FIXED : (m_acc ^ {32{psum_col}});
        end
    end

    task automatic run_job(input int nc, input int kb, input int vmode, input int rmode, input bit inj, input int abort_col);
        logic [127:0] acc, prev_data;
        logic [127:0] exp_q[$];
        logic [511:0] exp_pin;
        int col, beats, hold, istall, ostall, results, tog;
        bit stalled, last_acc, fin, injected;
        acc = '0; prev_data = '0; exp_pin = '0;
        col = 0; beats = 0; hold = 0; istall = 0; ostall = 0; results = 0; tog = 1;
        stalled = 0; last_acc = 0; fin = 0; injected = 0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        start = 1; cfg_ncols_m1 = nc[3:0]; cfg_kbeats_m1 = kb[7:0]; in_valid = 0; res_ready = 0;
        @(negedge clk);
        start = 0; cfg_ncols_m1 = 4'($urandom); cfg_kbeats_m1 = 8'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || psum_col !== 4'd0) begin
            n_bad++; $display("FAIL job_start: busy=%b in_ready=%b col=%0d want 1 1 0", busy, in_ready, psum_col);
        end
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            start = 0;
            n_cmp++;
            if (psum_in !== exp_pin) begin n_bad++; $display("FAIL psum_in: got %h want %h", psum_in, exp_pin); end
            if (last_acc) begin
                n_cmp++;
                if (in_ready !== 1'b0 || psum_out_en !== 1'b0) begin
                    n_bad++; $display("FAIL flush_lat: in_ready=%b psum_out_en=%b want 0 0", in_ready, psum_out_en);
                end
            end
            if (done === 1'b1) begin
                n_cmp++;
                if (results != nc + 1 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL job_end: results=%0d busy=%b want %0d 0", results, busy, nc + 1);
                end
                n_cmp++;
`ifdef USTC_PSUM_SCHED_PERF_EN
                if (perf_in_stall !== istall || perf_out_stall !== ostall) begin
                    n_bad++; $display("FAIL perf: in=%0d out=%0d want %0d %0d", perf_in_stall, perf_out_stall, istall, ostall);
                end
`else
                if (perf_in_stall !== 0 || perf_out_stall !== 0) begin
                    n_bad++; $display("FAIL perf_tied: in=%0d out=%0d want 0 0", perf_in_stall, perf_out_stall);
                end
`endif
                fin = 1;
                in_valid = 0;
                res_ready = 0;
            end else begin
                if (abort_col >= 0 && psum_out_en === 1'b1 && col == abort_col) begin
                    rst = 0;
                    #1;
                    n_cmp++;
                    if ({busy, done, in_ready, psum_out_en, res_valid} !== 5'b0 || psum_col !== 4'd0 ||
                        psum_in !== '0 || res_data !== '0 || res_col !== 4'd0) begin
                        n_bad++; $display("FAIL async_reset: busy=%b done=%b rdy=%b en=%b rv=%b col=%0d rcol=%0d data=%h want all 0",
                                          busy, done, in_ready, psum_out_en, res_valid, psum_col, res_col, res_data);
                    end
                    in_valid = 0; res_ready = 0;
                    repeat (2) begin
                        @(negedge clk);
                        n_cmp++;
                        if (done !== 1'b0 || busy !== 1'b0) begin
                            n_bad++; $display("FAIL reset_hold: done=%b busy=%b want 0 0", done, busy);
                        end
                    end
                    rst = 1;
                    return;
                end
                if (in_ready === 1'b1) begin
                    n_cmp++;
                    if (psum_col !== col || res_valid !== 1'b0 || beats > kb) begin
                        n_bad++; $display("FAIL feed_state: col=%0d rv=%b beats=%0d want col %0d rv 0 beats<=%0d", psum_col, res_valid, beats, col, kb);
                    end
                end
                if (res_valid === 1'b1) begin
                    n_cmp++;
                    if (in_ready !== 1'b0 || (stalled && res_data !== prev_data)) begin
                        n_bad++; $display("FAIL out_hold: in_ready=%b data=%h want 0 %h", in_ready, res_data, prev_data);
                    end
                    res_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : (hold >= 5);
                    if (res_ready) begin
                        n_cmp++;
                        if (exp_q.size() == 0 || res_data !== exp_q[0] || res_col !== col) begin
                            n_bad++; $display("FAIL result: data=%h col=%0d want %h col %0d", res_data, res_col,
                                              exp_q.size() ? exp_q[0] : 128'hx, col);
                        end
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        results++; col++; beats = 0; stalled = 0;
                    end else begin
                        hold++; ostall++; stalled = 1; prev_data = res_data;
                    end
                end else res_ready = 1'($urandom_range(0, 1));
                in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? tog[0] : 1'($urandom_range(0, 1));
                tog ^= 1;
                in_data = rand_beat();
                last_acc = 0;
                exp_pin = '0;
                if (in_ready === 1'b1) begin
                    if (in_valid) begin
                        acc ^= fold(in_data);
                        beats++;
                        exp_pin = in_data;
                        if (beats == kb + 1) begin
                            exp_q.push_back(fixed_mode ? FIXED : (acc ^ {32{col[3:0]}}));
                            acc = '0;
                            last_acc = 1;
                        end
                    end else istall++;
                    if (inj && !injected && col == 1) begin
                        start = 1;
                        cfg_ncols_m1 = 4'((nc + 5) % 16);
                        cfg_kbeats_m1 = 8'(kb + 3);
                        injected = 1;
                    end
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: job nc=%0d kb=%0d got no done within budget", nc, kb);
            in_valid = 0; res_ready = 0;
            return;
        end
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, in_ready, psum_out_en, res_valid} !== 5'b0 || psum_col !== 4'd0 ||
            psum_in !== '0 || res_data !== '0 || res_col !== 4'd0) begin
            n_bad++; $display("FAIL reset_state: busy=%b done=%b rdy=%b en=%b rv=%b want all 0", busy, done, in_ready, psum_out_en, res_valid);
        end
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_single();
        fixed_mode = 1;
        run_job(0, 0, 0, 0, 0, -1);
        fixed_mode = 0;
        n_cmp++;
        if (res_data !== FIXED || res_col !== 4'd0) begin
            n_bad++; $display("FAIL single_res: data=%h col=%0d want %h 0", res_data, res_col, FIXED);
        end
    endtask

    task automatic test_multi();
        run_job(3, 2, 0, 0, 0, -1);
        n_cmp++;
        if (res_col !== 4'd3) begin n_bad++; $display("FAIL multi_lastcol: got %0d want 3", res_col); end
    endtask

    task automatic test_toggle();
        run_job(3, 2, 1, 0, 0, -1);
    endtask

    task automatic test_out_stall();
        run_job(2, 1, 0, 2, 0, -1);
    endtask

    task automatic test_abort();
        run_job(4, 1, 0, 0, 0, 2);
        run_job(1, 3, 2, 1, 0, -1);
    endtask

    task automatic test_start_ignored();
        run_job(3, 1, 0, 0, 1, -1);
    endtask

    task automatic test_boundary();
        run_job(15, 0, 0, 0, 0, -1);
        n_cmp++;
        if (res_col !== 4'd15) begin n_bad++; $display("FAIL boundary_col: got %0d want 15", res_col); end
        run_job(0, $urandom_range(200, 255), 2, 1, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) run_job($urandom_range(0, 15), $urandom_range(0, 4), 2, 1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_toggle();
        test_out_stall();
        test_abort();
        test_start_ignored();
        test_boundary();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ustc_psum_sched.md
Name: ustc_psum_sched

Overview:
- Column scheduler for the unstructured-sparse partial-sum unit (ustc_psum).
- Accepts a job (column count, input beats per column) and streams NUM_IN-line packed input beats from an upstream valid/ready source into ustc_psum.
- Steps the column index, asserts the psum output enable per column, and captures each N-wide result.
- Hands each captured result to a downstream valid/ready sink.

Parameters:
- N, 16: psum output lanes per column result.
- NUM_IN, 32: packed input lines per beat.
- DW_DATA, 8: data width per line and per output lane.
- DW_ROW, 4: row-index field width per line.
- DW_CTRL, 4: control field width per line.
- DW_COL, 4: column index width.
- DW_KB, 8: beat-count config width.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL: derived line width.
- DW_OUT, N*DW_DATA: derived result width.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- start  in  1  job start pulse.
- cfg_ncols_m1  in  DW_COL  columns per job minus 1.
- cfg_kbeats_m1  in  DW_KB  input beats per column minus 1.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  scheduler accepts a beat.
- in_data  in  NUM_IN*DW_LINE  packed beat.
- psum_col  out  DW_COL  column index to ustc_psum.
- psum_in  out  NUM_IN*DW_LINE  lines to ustc_psum.
- psum_out_en  out  1  psum output request.
- psum_out_valid  in  1  psum result valid.
- psum_out  in  DW_OUT  psum result.
- res_valid  out  1  result valid to downstream.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DW_OUT  captured result.
- res_col  out  DW_COL  column of res_data.

Behaviour:
- Reset (async, rst=0): state IDLE; busy, done, in_ready, psum_out_en and res_valid are 0; psum_col, psum_in, res_data and res_col are 0. Reset mid-job aborts it with no done pulse.
- IDLE:
  - start=1 latches cfg_* and clears the column and beat counters.
  - Next cycle: state FEED, busy=1.
  - start while busy is ignored.
- FEED:
  - in_ready=1 (combinational from state).
  - A beat is accepted when in_valid&in_ready. psum_in is registered and carries the accepted beat in the following cycle only.
  - psum_in is all-zero in every cycle not carrying an accepted beat; ctrl=0 lines are psum no-ops, so bubbles are harmless.
  - psum_col holds the current column for the whole column period.
  - When the beat counter reaches cfg_kbeats_m1 on acceptance, the state moves to FLUSH and in_ready drops in the same next cycle.
- FLUSH:
  - psum_out_en=1, held until psum_out_valid=1.
  - On that cycle: res_data<=psum_out, res_col<=psum_col, state OUT.
  - psum_out_valid outside FLUSH is ignored.
- OUT:
  - res_valid=1; res_data and res_col stay stable until res_ready=1.
  - On handshake: if col==cfg_ncols_m1, go to IDLE with done=1 for one cycle and busy=0.
  - Otherwise col+1, beat counter cleared, state FEED.
- Latency: minimum 2 cycles from the last accepted beat to psum_out_en (1-cycle psum_in register).
- Boundaries:
  - cfg_kbeats_m1=0: one beat per column.
  - cfg_ncols_m1=N-1: col reaches 15 with no wrap, then the job ends.
  - Counters never wrap inside a job.
  - res_ready may be held high permanently: zero-stall handshake.

Optional Feature:
- Macro: USTC_PSUM_SCHED_PERF_EN.
- Defined:
  - 32-bit saturating counters perf_in_stall (FEED cycles with in_valid=0) and perf_out_stall (OUT cycles with res_ready=0).
  - Both cleared on the start that launches a job, and exported on outputs of the same names.
- Undefined: the ports exist but are tied to 0, and no counter logic is present.

Decomposition:
- Package ustc_pkg:
  - Width constants DW_DATA, DW_ROW, DW_CTRL, DW_COL, DW_LINE.
  - State encoding IDLE=0, FEED=1, FLUSH=2, OUT=3.
- Sub-module ustc_res_reg: single-entry result holding register (valid/ready, data+col) used for the OUT stage.
- The FSM and counters stay in the top module.

Test Plan:
- Single job, cfg_ncols_m1=0, cfg_kbeats_m1=0, psum model returns 0x0102…10 2 cycles after psum_out_en, res_ready=1 -> res_data=0x0102…10, res_col=0, then done pulses once and busy falls.
- cfg_ncols_m1=3, cfg_kbeats_m1=2, in_valid always 1 -> 12 beats accepted, psum_col steps 0,1,2,3, 4 results with res_col 0..3, psum_in is zero between column phases.
- in_valid toggling 1010 during FEED -> psum_in non-zero exactly one cycle after each accept; beat count per column stays 3; with PERF_EN, perf_in_stall equals the number of low cycles.
- res_ready held 0 for 5 cycles in OUT -> res_valid and res_data stable for all 5; no new beat accepted (in_ready=0); continues after res_ready=1.
- rst driven 0 mid-FLUSH in column 2 -> all outputs 0 immediately, no done; a following start with fresh cfg runs from col 0.
- start pulsed during FEED with different cfg -> ignored; the original job completes with the original column count.
